// File: rtl/modexp_pkg.sv
// modexp_pkg: shared definitions for the modular exponentiation engine.
//   state_e      : engine FSM state encoding (also exported on the debug port)
//   MODMULT_LAT  : cycles from mod_mult start pulse to its done pulse
//   idx_width    : width of an exponent bit index for a given exponent width
//   IDX_WIDTH    : index width for the default 32-bit exponent
package modexp_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_REDUCE = 3'd2,
        S_SQUARE = 3'd3,
        S_MULT   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    // One cycle per multiplier bit plus the cycle that presents the start.
    function automatic int MODMULT_LAT(input int key_width);
        return key_width + 1;
    endfunction

    // A 1-bit exponent still needs a 1-bit index register.
    function automatic int idx_width(input int exp_width);
        return (exp_width > 1) ? $clog2(exp_width) : 1;
    endfunction

    localparam int DEFAULT_EXP_WIDTH = 32;
    localparam int IDX_WIDTH         = idx_width(DEFAULT_EXP_WIDTH);

endpackage

// File: rtl/mod_mult.sv
// mod_mult: bit-serial interleaved shift-add modular multiplier, r = a*b mod m.
// Ports:
//   clk_in, rst_n_in : clock, asynchronous active-low reset
//   ready_in         : start request, accepted only when not busy
//   abort_in         : drop the running multiplication
//   a_in, b_in, m_in : operands, latched on accept; requires b < m
//   busy_out         : high from the accept edge until the done pulse
//   valid_out        : one-cycle done pulse, KEY_WIDTH cycles after accept
//   r_out            : result, valid while valid_out is high
// Handshake: ready_in is a request sampled on a rising edge while busy_out is
// low; that edge is the accept edge. valid_out rises exactly KEY_WIDTH edges
// later, on the same edge busy_out falls, so a new request can be presented in
// the valid_out cycle and accepted on the following edge.
module mod_mult #(
    parameter int KEY_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ready_in,
    input  logic                 abort_in,
    input  logic [KEY_WIDTH-1:0] a_in,
    input  logic [KEY_WIDTH-1:0] b_in,
    input  logic [KEY_WIDTH-1:0] m_in,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic [KEY_WIDTH-1:0] r_out
);

    localparam int CW = (KEY_WIDTH > 1) ? $clog2(KEY_WIDTH) : 1;

    logic [KEY_WIDTH-1:0] a_q, b_q, m_q, r_q;
    logic [CW-1:0]        j_q;
    logic                 busy_q, valid_q;

    // R < m and b < m, so 2R + b < 3m fits in KEY_WIDTH+2 bits and two
    // conditional subtractions bring it back below m.
    logic [KEY_WIDTH+1:0] sum, s1, s2, m_ext;

    always_comb begin
        m_ext = {2'b00, m_q};
        sum   = {1'b0, r_q, 1'b0} + {2'b00, (a_q[j_q] ? b_q : '0)};
        s1    = (sum >= m_ext) ? (sum - m_ext) : sum;
        s2    = (s1 >= m_ext) ? (s1 - m_ext) : s1;
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            r_q     <= '0;
            j_q     <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (abort_in) begin
                busy_q <= 1'b0;
            end else if (busy_q) begin
                r_q <= s2[KEY_WIDTH-1:0];
                if (j_q == '0) begin
                    busy_q  <= 1'b0;
                    valid_q <= 1'b1;
                end else begin
                    j_q <= j_q - 1'b1;
                end
            end else if (ready_in) begin
                a_q    <= a_in;
                b_q    <= b_in;
                m_q    <= m_in;
                r_q    <= '0;
                j_q    <= CW'(KEY_WIDTH - 1);
                busy_q <= 1'b1;
            end
        end
    end

    assign busy_out  = busy_q;
    assign valid_out = valid_q;
    assign r_out     = r_q;

endmodule

// File: rtl/mod_exp_engine.sv
// mod_exp_engine: value_in^exponent_in mod modulus_in, MSB-first
// square-and-multiply on top of the bit-serial mod_mult.
// Ports:
//   clk_in, rst_n_in  : clock, asynchronous active-low reset
//   ready_in          : start request, sampled only in IDLE
//   value_in          : base (MSG_WIDTH), may exceed the modulus
//   modulus_in        : modulus (KEY_WIDTH)
//   exponent_in       : exponent (EXP_WIDTH)
//   abort_in          : cancel the running operation
//   value_out         : result, held until the next completion
//   busy_out          : accept edge until the edge valid_out falls (or abort)
//   valid_out         : one-cycle completion pulse
//   error_out         : qualifies valid_out, modulus was zero
//   state_out         : current FSM state (debug)
// Handshake: ready_in is sampled on a rising edge while the FSM is IDLE, no
// completion pulse is showing and abort_in is low; that edge is the accept edge
// and latches all operands. valid_out pulses for one cycle; the next request is
// accepted on the edge after valid_out falls at the earliest.
// Build option MODEXP_LZ_SKIP_EN: start at the highest set exponent bit and
// skip multiplies for zero bits (faster, but the latency depends on the
// exponent). Undefined: constant-time square-and-multiply-always.
module mod_exp_engine
    import modexp_pkg::*;
#(
    parameter int MSG_WIDTH = 16,
    parameter int KEY_WIDTH = 32,
    parameter int EXP_WIDTH = 32
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic                 ready_in,
    input  logic [MSG_WIDTH-1:0] value_in,
    input  logic [KEY_WIDTH-1:0] modulus_in,
    input  logic [EXP_WIDTH-1:0] exponent_in,
    input  logic                 abort_in,
    output logic [KEY_WIDTH-1:0] value_out,
    output logic                 busy_out,
    output logic                 valid_out,
    output logic                 error_out,
    output logic [2:0]           state_out
);

    localparam int IW = idx_width(EXP_WIDTH);

    state_e               state_q, state_d;
    logic [MSG_WIDTH-1:0] value_q;
    logic [KEY_WIDTH-1:0] mod_q;
    logic [EXP_WIDTH-1:0] exp_q;
    logic [KEY_WIDTH-1:0] acc_q, acc_d;
    logic [KEY_WIDTH-1:0] base_q, base_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic                 err_q, err_d;
    logic [KEY_WIDTH-1:0] value_out_q;
    logic                 error_q, valid_q, busy_q;

    logic                 accept;
    logic                 mm_start, mm_busy, mm_valid;
    logic                 op_reduce, op_square;
    logic [KEY_WIDTH-1:0] mm_a, mm_b, mm_r;

    // Blocked while the completion pulse is showing so busy_out can fall
    // together with valid_out.
    assign accept = ready_in && !abort_in && !valid_q;

`ifdef MODEXP_LZ_SKIP_EN
    logic [IW-1:0] msb_idx;

    always_comb begin
        msb_idx = '0;
        for (int k = 0; k < EXP_WIDTH; k++) begin
            if (exp_q[k]) msb_idx = IW'(k);
        end
    end
`endif

    // The next multiplication is started in the cycle its predecessor reports
    // done, with operands taken from the next-state values, so every multiply
    // state lasts exactly MODMULT_LAT cycles.
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        base_d    = base_q;
        idx_d     = idx_q;
        err_d     = err_q;
        mm_start  = 1'b0;
        op_reduce = 1'b0;
        op_square = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    err_d   = 1'b0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (mod_q == '0) begin
                    acc_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else if (mod_q == KEY_WIDTH'(1)) begin
                    acc_d   = '0;
                    state_d = S_DONE;
                end else if (exp_q == '0) begin
                    acc_d   = KEY_WIDTH'(1);
                    state_d = S_DONE;
                end else begin
                    acc_d     = KEY_WIDTH'(1);
`ifdef MODEXP_LZ_SKIP_EN
                    idx_d     = msb_idx;
`else
                    idx_d     = IW'(EXP_WIDTH - 1);
`endif
                    state_d   = S_REDUCE;
                    mm_start  = 1'b1;
                    op_reduce = 1'b1;
                end
            end
            S_REDUCE: begin
                if (mm_valid) begin
                    base_d = mm_r;
`ifdef MODEXP_LZ_SKIP_EN
                    // The top exponent bit is 1 by construction: acc starts at b.
                    acc_d = mm_r;
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q - 1'b1;
                        state_d   = S_SQUARE;
                        mm_start  = 1'b1;
                        op_square = 1'b1;
                    end
`else
                    state_d   = S_SQUARE;
                    mm_start  = 1'b1;
                    op_square = 1'b1;
`endif
                end
            end
            S_SQUARE: begin
                if (mm_valid) begin
                    acc_d = mm_r;
`ifdef MODEXP_LZ_SKIP_EN
                    if (exp_q[idx_q]) begin
                        state_d  = S_MULT;
                        mm_start = 1'b1;
                    end else if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q - 1'b1;
                        state_d   = S_SQUARE;
                        mm_start  = 1'b1;
                        op_square = 1'b1;
                    end
`else
                    state_d  = S_MULT;
                    mm_start = 1'b1;
`endif
                end
            end
            S_MULT: begin
                if (mm_valid) begin
                    // The product is always computed; a zero bit discards it.
                    if (exp_q[idx_q]) acc_d = mm_r;
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q - 1'b1;
                        state_d   = S_SQUARE;
                        mm_start  = 1'b1;
                        op_square = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort_in && state_q != S_IDLE) begin
            state_d  = S_IDLE;
            mm_start = 1'b0;
        end

        mm_a = op_reduce ? {{(KEY_WIDTH - MSG_WIDTH){1'b0}}, value_q} : acc_d;
        mm_b = op_reduce ? KEY_WIDTH'(1) : (op_square ? acc_d : base_d);
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= S_IDLE;
            value_q     <= '0;
            mod_q       <= '0;
            exp_q       <= '0;
            acc_q       <= KEY_WIDTH'(1);
            base_q      <= '0;
            idx_q       <= '0;
            err_q       <= 1'b0;
            value_out_q <= '0;
            error_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            base_q  <= base_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            valid_q <= 1'b0;
            if (state_q == S_IDLE && accept) begin
                value_q <= value_in;
                mod_q   <= modulus_in;
                exp_q   <= exponent_in;
                busy_q  <= 1'b1;
            end
            if (state_q == S_DONE && !abort_in) begin
                value_out_q <= acc_q;
                error_q     <= err_q;
                valid_q     <= 1'b1;
            end
            if (valid_q || (abort_in && state_q != S_IDLE)) begin
                busy_q <= 1'b0;
            end
        end
    end

    mod_mult #(
        .KEY_WIDTH(KEY_WIDTH)
    ) u_mod_mult (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .ready_in (mm_start),
        .abort_in (abort_in && mm_busy),
        .a_in     (mm_a),
        .b_in     (mm_b),
        .m_in     (mod_q),
        .busy_out (mm_busy),
        .valid_out(mm_valid),
        .r_out    (mm_r)
    );

    assign value_out = value_out_q;
    assign error_out = error_q;
    assign valid_out = valid_q;
    assign busy_out  = busy_q;
    assign state_out = state_q;

endmodule
